// File: rtl/banked_reg_file.sv
// banked_reg_file: ARM7TDMI-style register file.
// Provides mode-banked R8-R14, a CPSR and per-mode SPSRs, and an
// auto-incrementing PC (R15). Exception entry and exception return each
// complete in a single clock edge. Three combinational read ports can
// optionally forward same-cycle write data.
module banked_reg_file #(
    parameter int          DATA_W     = 32,
    parameter int          PC_STEP    = 4,
    parameter logic [4:0]  RESET_MODE = 5'b10011,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    input  logic [3:0]        rd_addr_c,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] rd_data_c,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_inc,
    input  logic              flag_we,
    input  logic [3:0]        flags_in,
    input  logic              cpsr_we,
    input  logic [DATA_W-1:0] cpsr_in,
    input  logic              exc_req,
    input  logic [4:0]        exc_mode,
    input  logic [DATA_W-1:0] exc_lr,
    input  logic [DATA_W-1:0] exc_vector,
    input  logic              exc_ret,
    output logic [DATA_W-1:0] cpsr_out,
    output logic [DATA_W-1:0] spsr_out,
    output logic [DATA_W-1:0] pc_out,
    output logic              mode_err
);

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    // Only N,Z,C,V (31:28) and I,F,T,mode (7:0) exist; other bits read as 0.
    localparam logic [DATA_W-1:0] PSR_MASK  = DATA_W'(32'hF000_00FF);
    localparam logic [DATA_W-1:0] CPSR_RST  = DATA_W'({24'h0, 3'b110, RESET_MODE});
    localparam logic [DATA_W-1:0] PC_INCR   = DATA_W'(PC_STEP);

    // Register bank selector. USR and SYS share one bank; illegal codes
    // never reach the CPSR, so mapping them to USR is only a safe default.
    typedef enum logic [2:0] {
        BANK_USR = 3'd0,
        BANK_FIQ = 3'd1,
        BANK_IRQ = 3'd2,
        BANK_SVC = 3'd3,
        BANK_ABT = 3'd4,
        BANK_UND = 3'd5
    } bank_e;

    function automatic bank_e mode_to_bank(input logic [4:0] m);
        case (m)
            MODE_FIQ: return BANK_FIQ;
            MODE_IRQ: return BANK_IRQ;
            MODE_SVC: return BANK_SVC;
            MODE_ABT: return BANK_ABT;
            MODE_UND: return BANK_UND;
            default:  return BANK_USR;
        endcase
    endfunction

    function automatic logic mode_legal(input logic [4:0] m);
        case (m)
            MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
            MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // Architectural state.
    logic [DATA_W-1:0] gpr_q     [8];   // R0-R7, shared by all modes
    logic [DATA_W-1:0] usr_hi_q  [5];   // R8-R12, all modes except FIQ
    logic [DATA_W-1:0] fiq_hi_q  [5];   // R8-R12, FIQ copy
    logic [DATA_W-1:0] r13_q     [6];   // indexed by bank_e
    logic [DATA_W-1:0] r14_q     [6];   // indexed by bank_e
    logic [DATA_W-1:0] spsr_q    [6];   // USR entry is never written, stays 0
    logic [DATA_W-1:0] cpsr_q, cpsr_d;
    logic [DATA_W-1:0] pc_q,   pc_d;
    logic              mode_err_q, mode_err_d;

    // Per-edge control decisions.
    logic  wr_commit;   // the register write strobe takes effect this edge
    logic  exc_take;    // exception entry takes effect this edge
    logic  pc_free;     // normal PC sources (write R15 / pc_inc) are allowed
    bank_e cur_bank;
    bank_e exc_bank;
    logic [4:0]        cur_mode;
    logic [DATA_W-1:0] spsr_cur;
    logic [2:0]        wr_hi;

    assign cur_mode = cpsr_q[4:0];
    assign cur_bank = mode_to_bank(cur_mode);
    assign exc_bank = mode_to_bank(exc_mode);
    assign spsr_cur = spsr_q[cur_bank];
    assign wr_hi    = 3'(wr_addr - 4'd8);

    // Next-state for CPSR, PC and mode_err, with the exception / return /
    // MSR / flag priority chain resolved here.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        cpsr_d     = cpsr_q;
        pc_d       = pc_q;
        mode_err_d = 1'b0;
        wr_commit  = 1'b0;
        exc_take   = 1'b0;
        pc_free    = 1'b0;

        if (exc_req) begin
            if (mode_legal(exc_mode) && exc_mode != MODE_USR && exc_mode != MODE_SYS) begin
                exc_take      = 1'b1;
                cpsr_d[4:0]   = exc_mode;
                cpsr_d[5]     = 1'b0;
                cpsr_d[7]     = 1'b1;
                if (exc_mode == MODE_FIQ) begin
                    cpsr_d[6] = 1'b1;
                end
                pc_d          = exc_vector;
            end else begin
                mode_err_d = 1'b1;
            end
        end else if (exc_ret) begin
            // Returning needs an SPSR, so USR/SYS cannot return. An SPSR that
            // was never loaded (still 0 after reset) holds no legal mode and
            // is refused the same way rather than corrupting the CPSR.
            if (cur_bank != BANK_USR && mode_legal(spsr_cur[4:0])) begin
                cpsr_d    = spsr_cur;
                wr_commit = wr_en;
                pc_free   = 1'b1;
            end else begin
                mode_err_d = 1'b1;
            end
        end else begin
            wr_commit = wr_en;
            pc_free   = 1'b1;
            if (cpsr_we) begin
                if (cur_mode == MODE_USR) begin
                    cpsr_d[31:28] = cpsr_in[31:28];
                end else if (mode_legal(cpsr_in[4:0])) begin
                    cpsr_d = cpsr_in & PSR_MASK;
                end else begin
                    mode_err_d = 1'b1;
                end
            end else if (flag_we) begin
                cpsr_d[31:28] = flags_in;
            end
        end

        if (pc_free) begin
            if (wr_commit && wr_addr == 4'd15) begin
                pc_d = wr_data;
            end else if (pc_inc) begin
                pc_d = pc_q + PC_INCR;
            end
        end
    end

    // Combinational read ports resolved through the current mode.
    logic [3:0]        rd_addr [3];
    logic [DATA_W-1:0] rd_val  [3];

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;
    assign rd_addr[2] = rd_addr_c;

    // Read mux: R15 shows the PC, then same-cycle forwarding, then storage.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_val[p] = '0;
            if (rd_addr[p] == 4'd15) begin
                rd_val[p] = pc_q;
            end else if (BYPASS && wr_commit && wr_addr == rd_addr[p]) begin
                rd_val[p] = wr_data;
            end else if (rd_addr[p] < 4'd8) begin
                rd_val[p] = gpr_q[rd_addr[p][2:0]];
            end else if (rd_addr[p] < 4'd13) begin
                if (cur_bank == BANK_FIQ) begin
                    rd_val[p] = fiq_hi_q[3'(rd_addr[p] - 4'd8)];
                end else begin
                    rd_val[p] = usr_hi_q[3'(rd_addr[p] - 4'd8)];
                end
            end else if (rd_addr[p] == 4'd13) begin
                rd_val[p] = r13_q[cur_bank];
            end else begin
                rd_val[p] = r14_q[cur_bank];
            end
        end
    end

    assign rd_data_a = rd_val[0];
    assign rd_data_b = rd_val[1];
    assign rd_data_c = rd_val[2];

    // State registers: synchronous reset, then PSR/PC update and banked writes.
    always_ff @(posedge clock) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples pre-edge values, whatever the statement order.
        if (reset) begin
            // NOTE: the register arrays are flops, not RAM macros, and must
            // read 0 after reset, so they are cleared explicitly.
            for (int i = 0; i < 8; i++) gpr_q[i] <= '0;
            for (int i = 0; i < 5; i++) begin
                usr_hi_q[i] <= '0;
                fiq_hi_q[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                r13_q[i]  <= '0;
                r14_q[i]  <= '0;
                spsr_q[i] <= '0;
            end
            cpsr_q     <= CPSR_RST;
            pc_q       <= '0;
            mode_err_q <= 1'b0;
        end else begin
            cpsr_q     <= cpsr_d;
            pc_q       <= pc_d;
            mode_err_q <= mode_err_d;

            if (exc_take) begin
                spsr_q[exc_bank] <= cpsr_q;
                r14_q[exc_bank]  <= exc_lr;
            end

            if (wr_commit) begin
                if (wr_addr < 4'd8) begin
                    gpr_q[wr_addr[2:0]] <= wr_data;
                end else if (wr_addr < 4'd13) begin
                    if (cur_bank == BANK_FIQ) begin
                        fiq_hi_q[wr_hi] <= wr_data;
                    end else begin
                        usr_hi_q[wr_hi] <= wr_data;
                    end
                end else if (wr_addr == 4'd13) begin
                    r13_q[cur_bank] <= wr_data;
                end else if (wr_addr == 4'd14) begin
                    r14_q[cur_bank] <= wr_data;
                end
            end
        end
    end

    assign cpsr_out = cpsr_q;
    assign spsr_out = spsr_cur;
    assign pc_out   = pc_q;
    assign mode_err = mode_err_q;

endmodule

// File: doc/banked_reg_file.md
Name: banked_reg_file

Overview:
Parametrised successor to the core register file, built for the ARM7TDMI datapath. Adds mode-banked R8–R14 (USR/SYS, FIQ, IRQ, SVC, ABT, UND), a real CPSR and per-mode SPSRs, and a PC (R15) with auto-increment. Adds atomic single-cycle exception entry and exception return, and a third read port with optional write-to-read bypass. Sits between the decode stage and the ALU/MAC operand muxes.

Parameters:
DATA_W, 32, register/PSR data width (≥32; PSR fields occupy bits 31:28, 7:0)
PC_STEP, 4, PC increment per pc_inc cycle (2 for Thumb builds)
RESET_MODE, 5'b10011, CPSR mode field after reset (SVC)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
rd_addr_a/b/c  in  4 each  read register numbers (current-mode view)
rd_data_a/b/c  out  DATA_W each  read data, combinational
wr_en  in  1  register write strobe
wr_addr  in  4  write register number (current-mode view)
wr_data  in  DATA_W  write data
pc_inc  in  1  advance PC by PC_STEP
flag_we  in  1  update CPSR[31:28] from flags_in
flags_in  in  4  {N,Z,C,V} from ALU/MAC
cpsr_we  in  1  MSR-style full CPSR write
cpsr_in  in  DATA_W  CPSR write data
exc_req  in  1  exception entry strobe
exc_mode  in  5  target mode code
exc_lr  in  DATA_W  return address for banked R14
exc_vector  in  DATA_W  new PC value
exc_ret  in  1  exception return (CPSR <= SPSR_current)
cpsr_out  out  DATA_W  current CPSR
spsr_out  out  DATA_W  SPSR of current mode (0 in USR/SYS)
pc_out  out  DATA_W  current R15
mode_err  out  1  one-cycle pulse on an illegal mode operation

Behaviour:
- Reset (sync, clock edge with reset=1): all GPRs, banked regs, SPSRs and PC cleared to 0; CPSR = {N,Z,C,V=0, I=1, F=1, T=0, mode=RESET_MODE} (32'h0000_00D3 by default); mode_err=0. Reset overrides every other input in that cycle.
- Mode codes: USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111. Any other code is illegal.
- Banking: R0–R7 are shared. R8–R12 have a separate FIQ copy. R13–R14 have one copy for USR/SYS and one per exception mode. R15 is the PC. Reads and writes resolve through CPSR.mode as it stands before the clock edge.
- Read: zero latency. With BYPASS=1, wr_en=1 and wr_addr==rd_addr (same bank), rd_data returns wr_data. Reading R15 returns pc_out. With BYPASS=0, written data is visible from the next cycle.
- Write: registered on the clock edge. A write to R15 loads PC = wr_data and overrides pc_inc.
- PC: PC += PC_STEP modulo 2^DATA_W (wraps silently) when pc_inc=1 and no higher-priority PC source is active.
- CPSR priority, highest first: exc_req > exc_ret > cpsr_we > flag_we.
- In USR mode, cpsr_we updates only bits 31:28; control bits are protected and mode_err stays 0.
- cpsr_we with an illegal mode field (privileged mode): the CPSR is left unchanged and mode_err pulses.
- flag_we together with cpsr_we: cpsr_we wins entirely.
- Exception entry (exc_req=1, legal exc_mode other than USR/SYS), all in one edge:
  - SPSR_exc_mode <= CPSR
  - R14_exc_mode <= exc_lr
  - CPSR.mode <= exc_mode; I <= 1; F <= 1 only if FIQ; T <= 0
  - PC <= exc_vector
  - wr_en, pc_inc, flag_we and cpsr_we are ignored that cycle.
- exc_req with an illegal mode, USR or SYS: no state change; mode_err pulses.
- Exception return (exc_ret=1, no exc_req): CPSR <= SPSR_current. If wr_en=1 with wr_addr=15, PC <= wr_data in the same edge (MOVS PC,LR). If the current mode is USR or SYS: no change; mode_err pulses.
- spsr_out and cpsr_out are registered values, visible one cycle after the updating edge.

Test Plan:
- Reset, then idle → cpsr_out=32'h0000_00D3, pc_out=0, all rd_data=0; pc_inc for 3 cycles → pc_out=12.
- In SVC, write R13=32'hAAAA_0000; cpsr_we to IRQ (32'h0000_00D2); write R13=32'hBBBB_0000; read R13 → BBBB_0000; return to SVC → reads AAAA_0000.
- CPSR=32'h6000_0013; exc_req with mode=FIQ, exc_lr=32'h104, exc_vector=32'h1C → cpsr_out=32'h6000_00D1, SPSR_fiq=32'h6000_0013, R14=32'h104, pc_out=32'h1C. Then exc_ret with wr_addr=15, wr_data=32'h100 → CPSR=32'h6000_0013, pc_out=32'h100.
- BYPASS=1: same cycle wr_en, wr_addr=3, wr_data=32'hDEAD_BEEF, rd_addr_a=3 → rd_data_a=32'hDEAD_BEEF combinationally.
- In USR: cpsr_we=32'hF000_00D3 → CPSR=32'hF000_0010, mode_err=0. Then exc_req with exc_mode=5'b00101 → state unchanged, mode_err=1 for exactly one cycle.
- pc_out=32'hFFFF_FFFC with pc_inc → pc_out=0. Simultaneous flag_we and cpsr_we → cpsr_in wins. Reset asserted one cycle after exc_req → CPSR back to 32'h0000_00D3.
